// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type codes, header length width,
// arbiter port-state encodings and the input-buffer framing state type.
package noc_pkg;

    localparam int LEN_W = 12;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    // One-hot arbiter port states; an input buffer's grant is one bit of these.
    localparam logic [5:0] IDLE = 6'b000001;
    localparam logic [5:0] L    = 6'b000010;
    localparam logic [5:0] N    = 6'b000100;
    localparam logic [5:0] E    = 6'b001000;
    localparam logic [5:0] W    = 6'b010000;
    localparam logic [5:0] S    = 6'b100000;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } ibuf_state_e;

    function automatic logic is_header(input logic [2:0] id);
        return id == FLIT_HEADER;
    endfunction

    // Any code other than header/tail travels as a body flit.
    function automatic logic is_tail(input logic [2:0] id);
        return id == FLIT_TAIL;
    endfunction

endpackage

// File: rtl/noc_input_buffer_if.sv
// Handshake bundle between an input port, its buffer, the arbiter and the crossbar.
interface noc_input_buffer_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) ();
    import noc_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_flit_id;
    logic [DW-1:0]    in_data;
    logic             grant;
    logic             out_ready;
    logic             req;
    logic [2:0]       flit_id;
    logic [LEN_W-1:0] length;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    count;
    logic             framing_err;

    // Buffer side.
    modport slave (
        input  in_valid, in_flit_id, in_data, grant, out_ready,
        output in_ready, req, flit_id, length, out_valid, out_data, count, framing_err
    );

    // Upstream / arbiter / crossbar side.
    modport master (
        output in_valid, in_flit_id, in_data, grant, out_ready,
        input  in_ready, req, flit_id, length, out_valid, out_data, count, framing_err
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port; reads 0 while empty.
module noc_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_input_buffer.sv
// Router input stage: buffers flits, tracks packet framing, requests the
// arbiter while a packet is in flight and pops toward the crossbar on grant.
module noc_input_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    noc_input_buffer_if.slave bus
);
    import noc_pkg::*;

    ibuf_state_e      state;
    logic [DW+2:0]    head;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   fifo_count;
    logic             head_hdr;
    logic             head_tail;
    logic             xfer_pop;
    logic             discard;

    assign head_hdr  = is_header(head[DW+2:DW]);
    assign head_tail = is_tail(head[DW+2:DW]);

    // Forward pop while granted in a packet; in IDLE any non-header head is dropped.
    assign xfer_pop = (state == ST_XFER) && !empty && bus.grant && bus.out_ready;
    assign discard  = (state == ST_IDLE) && !empty && !head_hdr;

    noc_sync_fifo #(
        .WIDTH (DW + 3),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (xfer_pop || discard),
        .wdata ({bus.in_flit_id, bus.in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.flit_id   = head[DW+2:DW];
    assign bus.out_data  = head[DW-1:0];
    assign bus.count     = fifo_count;
    // Decoded from registers only, so it drops at once on under-run or reset.
    assign bus.req       = (state == ST_XFER) && !empty;

    // Framing FSM with registered length and sticky framing error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            bus.length      <= '0;
            bus.framing_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        if (head_hdr) begin
                            state      <= ST_XFER;
                            bus.length <= head[LEN_W-1:0];
                        end else begin
                            bus.framing_err <= 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    if (xfer_pop && head_tail) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer with a queue-level reference model.
module tb_noc_input_buffer;
    import noc_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic [2:0]    id;
        logic [DW-1:0] d;
    } flit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    bit   chk_en  = 1'b0;

    // Reference model state
    flit_t       q[$];
    bit          m_xfer = 1'b0;
    logic [11:0] m_len  = '0;
    bit          m_ferr = 1'b0;

    noc_input_buffer_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    noc_input_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: packet-level rules applied to a plain queue at each rising edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            automatic bit have = (q.size() != 0);
            automatic bit push = bus.in_valid && (q.size() != DEPTH);
            automatic flit_t nf;
            nf.id = bus.in_flit_id;
            nf.d  = bus.in_data;
            if (have && !m_xfer) begin
                if (q[0].id == FLIT_HEADER) begin
                    m_xfer = 1'b1;
                    m_len  = q[0].d[11:0];
                end else begin
                    m_ferr = 1'b1;
                    void'(q.pop_front());
                end
            end else if (have && m_xfer && bus.grant && bus.out_ready) begin
                if (q[0].id == FLIT_TAIL) m_xfer = 1'b0;
                void'(q.pop_front());
            end
            if (push) q.push_back(nf);
        end
    end

    initial forever begin
        @(negedge rst);
        q.delete();
        m_xfer = 1'b0;
        m_len  = '0;
        m_ferr = 1'b0;
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (rst && chk_en) begin
            automatic int n = q.size();
            chk("in_ready",    64'(bus.in_ready),    64'(n != DEPTH));
            chk("out_valid",   64'(bus.out_valid),   64'(n != 0));
            chk("count",       64'(bus.count),       64'(n));
            chk("flit_id",     64'(bus.flit_id),     n != 0 ? 64'(q[0].id) : 64'd0);
            chk("out_data",    64'(bus.out_data),    n != 0 ? 64'(q[0].d) : 64'd0);
            chk("req",         64'(bus.req),         64'(m_xfer && n != 0));
            chk("length",      64'(bus.length),      64'(m_len));
            chk("framing_err", 64'(bus.framing_err), 64'(m_ferr));
        end
    end

    // Present one flit (or idle) for one rising edge, ending at the next falling edge.
    task automatic cyc(input logic v, input logic [2:0] id, input logic [DW-1:0] d);
        bus.in_valid   = v;
        bus.in_flit_id = id;
        bus.in_data    = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_flit_id = '0;
        bus.in_data    = '0;
        bus.grant      = 1'b0;
        bus.out_ready  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count",  64'(bus.count), 64'd0);
        chk("rst_req",    64'(bus.req), 64'd0);
        chk("rst_valid",  64'(bus.out_valid), 64'd0);
        chk("rst_len",    64'(bus.length), 64'd0);
        chk("rst_ferr",   64'(bus.framing_err), 64'd0);
        chk("rst_fid",    64'(bus.flit_id), 64'd0);
        chk("rst_data",   64'(bus.out_data), 64'd0);
        chk("rst_ready",  64'(bus.in_ready), 64'd1);
        rst    = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 1: header(len 20), body, tail streamed while granted
        bus.grant = 1'b1; bus.out_ready = 1'b1;
        cyc(1'b1, FLIT_HEADER, 32'hA000_0014);
        chk("t1_req_hdr", 64'(bus.req), 64'd0);
        cyc(1'b1, FLIT_BODY, 32'hA000_0001);
        chk("t1_req_up", 64'(bus.req), 64'd1);
        chk("t1_len", 64'(bus.length), 64'd20);
        cyc(1'b1, FLIT_TAIL, 32'hA000_0002);
        idle(4);
        chk("t1_req_end", 64'(bus.req), 64'd0);
        chk("t1_cnt_end", 64'(bus.count), 64'd0);

        // 2: fill to 8 without grant, 9th ignored, then drain 8 in order
        bus.grant = 1'b0;
        cyc(1'b1, FLIT_HEADER, 32'h0000_0008);
        for (int i = 0; i < 6; i++) cyc(1'b1, FLIT_BODY, 32'h100 + 32'(i));
        cyc(1'b1, FLIT_TAIL, 32'h0000_0200);
        chk("t2_full_cnt", 64'(bus.count), 64'd8);
        chk("t2_full_rdy", 64'(bus.in_ready), 64'd0);
        cyc(1'b1, FLIT_BODY, 32'h0000_DEAD);
        chk("t2_ninth", 64'(bus.count), 64'd8);
        bus.grant = 1'b1;
        idle(7);
        chk("t2_seven", 64'(bus.count), 64'd1);
        idle(1);
        chk("t2_eight", 64'(bus.count), 64'd0);
        idle(2);

        // 3: body at head in IDLE is discarded and flagged; next header still works
        cyc(1'b1, FLIT_BODY, 32'h0000_0BAD);
        cyc(1'b0, 3'b000, '0);
        chk("t3_ferr", 64'(bus.framing_err), 64'd1);
        chk("t3_cnt", 64'(bus.count), 64'd0);
        cyc(1'b1, FLIT_HEADER, 32'h0000_0003);
        cyc(1'b1, FLIT_TAIL, 32'h0000_0333);
        idle(3);
        chk("t3_len", 64'(bus.length), 64'd3);
        chk("t3_ferr_sticky", 64'(bus.framing_err), 64'd1);

        // 4: under-run mid-packet drops req until the tail arrives
        cyc(1'b1, FLIT_HEADER, 32'h0000_0007);
        cyc(1'b1, FLIT_BODY, 32'h0000_0444);
        chk("t4_req_a", 64'(bus.req), 64'd1);
        idle(1);
        chk("t4_req_b", 64'(bus.req), 64'd1);
        idle(1);
        chk("t4_req_gap", 64'(bus.req), 64'd0);
        idle(1);
        chk("t4_req_gap2", 64'(bus.req), 64'd0);
        cyc(1'b1, FLIT_TAIL, 32'h0000_0445);
        chk("t4_req_back", 64'(bus.req), 64'd1);
        idle(3);
        chk("t4_done", 64'(bus.count), 64'd0);

        // 5: push and pop together at count 4 across pointer wrap
        bus.grant = 1'b0;
        cyc(1'b1, FLIT_HEADER, 32'h0000_000A);
        for (int i = 0; i < 3; i++) cyc(1'b1, FLIT_BODY, 32'h400 + 32'(i));
        chk("t5_fill", 64'(bus.count), 64'd4);
        bus.grant = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, FLIT_BODY, 32'h500 + 32'(i));
        chk("t5_steady", 64'(bus.count), 64'd4);
        cyc(1'b1, FLIT_TAIL, 32'h0000_05FF);
        idle(6);
        chk("t5_drain", 64'(bus.count), 64'd0);

        // 6: asynchronous reset mid-packet, orphan tail afterwards
        cyc(1'b1, FLIT_HEADER, 32'h0000_0005);
        cyc(1'b1, FLIT_BODY, 32'h0000_0666);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_req", 64'(bus.req), 64'd0);
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_cnt", 64'(bus.count), 64'd0);
        chk("t6_len", 64'(bus.length), 64'd0);
        chk("t6_ferr", 64'(bus.framing_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, FLIT_TAIL, 32'h0000_0667);
        cyc(1'b0, 3'b000, '0);
        chk("t6_orphan", 64'(bus.framing_err), 64'd1);
        chk("t6_cnt_end", 64'(bus.count), 64'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
